// File: rtl/axis_dsm_decimator.sv
// Third-order CIC decimator for delta-sigma modulator streams with AXI-Stream ports.
// One signed PCM sample is produced for every DECIM accepted input beats.
module axis_dsm_decimator #(
  parameter int IN_WIDTH  = 6,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 aclk,
  input  logic                 arst_n,
  input  logic [IN_WIDTH-1:0]  s_axis_data_tdata,
  input  logic                 s_axis_data_tvalid,
  output logic                 s_axis_data_tready,
  output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  input  logic                 m_axis_data_tready
);

  localparam int W_IN   = (IN_WIDTH > 1) ? IN_WIDTH : 2;
  localparam int LOG2_D = $clog2(DECIM);
  localparam int ACC_W  = W_IN + 3 * LOG2_D;
  localparam int SHIFT  = ACC_W - OUT_WIDTH;
  localparam int CNT_W  = LOG2_D;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  if (OUT_WIDTH > ACC_W) begin : g_bad_out_width
    $error("axis_dsm_decimator: OUT_WIDTH larger than accumulator width");
  end
  if ((DECIM < 4) || (DECIM > 256) || ((DECIM & (DECIM - 1)) != 0)) begin : g_bad_decim
    $error("axis_dsm_decimator: DECIM must be a power of two in 4..256");
  end

  // A 1-bit stream encodes +1/-1; wider words are already two's complement.
  function automatic logic [ACC_W-1:0] map_sample(input logic [IN_WIDTH-1:0] d);
    logic [W_IN-1:0] v;
    if (IN_WIDTH == 1) begin
      v = d[0] ? {{(W_IN-1){1'b0}}, 1'b1} : {W_IN{1'b1}};
    end else begin
      v = W_IN'(d);
    end
    return {{(ACC_W-W_IN){v[W_IN-1]}}, v};
  endfunction

  logic [ACC_W-1:0]     x_s;
  logic [ACC_W-1:0]     i1_r, i2_r, i3_r;
  logic [ACC_W-1:0]     d1_r, d2_r, d3_r;
  logic [ACC_W-1:0]     i3n_s, c1_s, c2_s, c3_s;
  logic [OUT_WIDTH-1:0] out_next_s;
  logic [CNT_W-1:0]     cnt_r;
  logic                 last_phase_s;
  logic                 ready_s;
  logic                 accept_s;
  logic                 block_done_s;
  logic [OUT_WIDTH-1:0] out_data_r;
  logic                 out_valid_r;

  // Handshake decode and comb-stage arithmetic for the current beat.
  always_comb begin
    x_s          = map_sample(s_axis_data_tdata);
    last_phase_s = (cnt_r == CNT_LAST);
    if (!arst_n) begin
      ready_s = 1'b0;
    end else if (last_phase_s && out_valid_r) begin
      ready_s = m_axis_data_tready;
    end else begin
      ready_s = 1'b1;
    end
    accept_s     = s_axis_data_tvalid && ready_s;
    block_done_s = accept_s && last_phase_s;
    i3n_s        = i3_r + i2_r;
    c1_s         = i3n_s - d1_r;
    c2_s         = c1_s - d2_r;
    c3_s         = c2_s - d3_r;
    out_next_s   = OUT_WIDTH'($signed(c3_s) >>> SHIFT);
  end

  // Integrator chain; each stage uses the previous stage's pre-update value.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      i1_r <= {ACC_W{1'b0}};
      i2_r <= {ACC_W{1'b0}};
      i3_r <= {ACC_W{1'b0}};
    end else if (accept_s) begin
      i1_r <= i1_r + x_s;
      i2_r <= i2_r + i1_r;
      i3_r <= i3_r + i2_r;
    end
  end

  // Phase counter and comb delay registers, advanced at the decimated rate.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      d1_r  <= {ACC_W{1'b0}};
      d2_r  <= {ACC_W{1'b0}};
      d3_r  <= {ACC_W{1'b0}};
    end else if (block_done_s) begin
      cnt_r <= {CNT_W{1'b0}};
      d1_r  <= i3n_s;
      d2_r  <= c1_s;
      d3_r  <= c2_s;
    end else if (accept_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Output holding register; a new sample may replace one consumed on the same edge.
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      out_data_r  <= {OUT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
    end else if (block_done_s) begin
      out_data_r  <= out_next_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && m_axis_data_tready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign s_axis_data_tready = ready_s;
  assign m_axis_data_tdata  = out_data_r;
  assign m_axis_data_tvalid = out_valid_r;

endmodule

// File: tb/tb_axis_dsm_decimator.sv
// Randomized bench for axis_dsm_decimator: a 6-bit default instance and a 1-bit stream instance,
// both checked every cycle against a convolution model of the CIC response.
module tb_axis_dsm_decimator;

  localparam int D     = 64;
  localparam int KLEN  = 3 * D - 2;
  localparam int HSIZE = 256;

  logic       aclk;
  logic       arst_n;
  logic       s_valid;
  logic       m_ready;
  logic [5:0] s_data0;
  logic [0:0] s_data1;
  logic        s_ready0, s_ready1;
  logic [15:0] m_data0, m_data1;
  logic        m_valid0, m_valid1;

  int n_checks;
  int n_fail;

  int h[0:KLEN-1];
  int cnt_m[2];
  bit pend_m[2];
  int data_m[2];
  int n_m[2];
  int hist[2][HSIZE];
  int last_out[2];

  axis_dsm_decimator dut0 (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .s_axis_data_tdata  (s_data0),
    .s_axis_data_tvalid (s_valid),
    .s_axis_data_tready (s_ready0),
    .m_axis_data_tdata  (m_data0),
    .m_axis_data_tvalid (m_valid0),
    .m_axis_data_tready (m_ready)
  );

  axis_dsm_decimator #(.IN_WIDTH(1), .DECIM(64), .OUT_WIDTH(16)) dut1 (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .s_axis_data_tdata  (s_data1),
    .s_axis_data_tvalid (s_valid),
    .s_axis_data_tready (s_ready1),
    .m_axis_data_tdata  (m_data1),
    .m_axis_data_tvalid (m_valid1),
    .m_axis_data_tready (m_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // CIC output: input convolved with box^3, delayed two beats, wrapped to ACC_W, then shifted.
  function automatic int model_out(input int id, input int n);
    longint acc;
    longint m;
    int acc_w;
    int sh;
    int idx;
    acc = 0;
    for (int j = 0; j < KLEN; j++) begin
      idx = n - 2 - j;
      if (idx >= 0) acc += longint'(h[j]) * longint'(hist[id][idx % HSIZE]);
    end
    acc_w = (id == 0) ? 24 : 20;
    sh    = (id == 0) ? 8 : 4;
    m = acc & ((64'sd1 <<< acc_w) - 64'sd1);
    if (m >= (64'sd1 <<< (acc_w - 1))) m -= (64'sd1 <<< acc_w);
    m = m >>> sh;
    return int'(m);
  endfunction

  task automatic model_step(input int id, input logic s_rdy, input logic m_vld,
                            input int m_dat, input int x);
    bit exp_ready;
    bit accept;
    string pfx;
    pfx = (id == 0) ? "w6" : "w1";
    if (!arst_n) begin
      check_val({pfx, "_rst_s_tready"}, longint'(s_rdy), 0);
      check_val({pfx, "_rst_m_tvalid"}, longint'(m_vld), 0);
      check_val({pfx, "_rst_m_tdata"}, longint'(m_dat), 0);
      cnt_m[id] = 0; pend_m[id] = 1'b0; data_m[id] = 0; n_m[id] = 0;
      for (int k = 0; k < HSIZE; k++) hist[id][k] = 0;
    end else begin
      exp_ready = (cnt_m[id] == D - 1 && pend_m[id]) ? bit'(m_ready) : 1'b1;
      check_val({pfx, "_s_tready"}, longint'(s_rdy), longint'(exp_ready));
      check_val({pfx, "_m_tvalid"}, longint'(m_vld), longint'(pend_m[id]));
      check_val({pfx, "_m_tdata"}, longint'(m_dat), longint'(data_m[id]));
      if (pend_m[id] && m_ready) last_out[id] = m_dat;
      accept = s_valid && exp_ready;
      if (accept && cnt_m[id] == D - 1) begin
        hist[id][n_m[id] % HSIZE] = x;
        data_m[id] = model_out(id, n_m[id]);
        pend_m[id] = 1'b1;
        cnt_m[id] = 0;
        n_m[id]++;
      end else begin
        if (accept) begin
          hist[id][n_m[id] % HSIZE] = x;
          cnt_m[id]++;
          n_m[id]++;
        end
        if (pend_m[id] && m_ready) pend_m[id] = 1'b0;
      end
    end
  endtask

  // Compare both DUTs against the model away from the active edge, then advance the model.
  always @(negedge aclk) begin
    model_step(0, s_ready0, m_valid0, int'($signed(m_data0)), int'($signed(s_data0)));
    model_step(1, s_ready1, m_valid1, int'($signed(m_data1)), s_data1[0] ? 1 : -1);
  end

  task automatic drive(input int cycles, input int d0mode, input int d0val,
                       input int vmode, input int rmode, input int d1mode);
    for (int i = 0; i < cycles; i++) begin
      @(posedge aclk);
      #1;
      s_data0 = (d0mode == 0) ? 6'(d0val) : 6'($urandom);
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = 1'((i % 2) == 0);
        default: s_valid = 1'($urandom);
      endcase
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom);
      endcase
      case (d1mode)
        0:       s_data1 = 1'b1;
        1:       s_data1 = 1'(i % 2);
        default: s_data1 = 1'($urandom);
      endcase
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge aclk);
    #1;
    arst_n = 1'b0;
    repeat (cycles) @(posedge aclk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    int h2[0:2*D-2];
    n_checks = 0;
    n_fail   = 0;
    for (int k = 0; k < 2 * D - 1; k++) h2[k] = 0;
    for (int k = 0; k < KLEN; k++) h[k] = 0;
    for (int a = 0; a < D; a++)
      for (int b = 0; b < D; b++) h2[a + b]++;
    for (int a = 0; a < 2 * D - 1; a++)
      for (int b = 0; b < D; b++) h[a + b] += h2[a];
    for (int id = 0; id < 2; id++) begin
      cnt_m[id] = 0; pend_m[id] = 1'b0; data_m[id] = 0; n_m[id] = 0; last_out[id] = 0;
      for (int k = 0; k < HSIZE; k++) hist[id][k] = 0;
    end

    arst_n  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data0 = 6'd0;
    s_data1 = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    arst_n = 1'b1;

    drive(320, 0, 1, 0, 0, 0);
    check_val("dc_plus1", longint'(last_out[0]), 1024);
    check_val("dc_ones_1bit", longint'(last_out[1]), 16384);

    drive(320, 0, 31, 0, 0, 1);
    check_val("dc_plus31", longint'(last_out[0]), 31744);
    check_val("alt_1bit", longint'(last_out[1]), 0);

    drive(320, 0, -32, 0, 0, 0);
    check_val("dc_minus32", longint'(last_out[0]), -32768);

    drive(200, 0, 1, 0, 1, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(100, 0, 1, 0, 1, 0);
    drive(400, 0, 1, 0, 0, 0);
    check_val("backpressure_plus1", longint'(last_out[0]), 1024);

    drive(640, 0, 1, 1, 0, 0);
    check_val("gaps_plus1", longint'(last_out[0]), 1024);
    check_val("gaps_ones_1bit", longint'(last_out[1]), 16384);

    drive(3000, 1, 0, 2, 2, 2);

    drive(10, 0, 5, 0, 0, 0);
    do_reset(2);
    drive(300, 0, 1, 0, 0, 0);
    check_val("after_reset_plus1", longint'(last_out[0]), 1024);

    drive(70, 0, 1, 0, 1, 0);
    do_reset(2);
    drive(130, 0, 1, 0, 0, 0);

    drive(1500, 1, 0, 2, 2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
